frog_controller: RTL and testbench
==================================

FROG_CONTROLLER -- requirements
Module: frog_controller

Interface
REQ-001 SHALL have parameter TILE_SIZE, default 32, meaning the frog step and tile edge in pixels.
REQ-002 SHALL have parameter START_X, default 320, meaning the spawn X.
REQ-003 SHALL have parameter START_Y, default 448, meaning the spawn Y.
REQ-004 SHALL have parameter LIVES, default 3, meaning the lives at game start (1..3).
REQ-005 SHALL have parameter MOVE_COOLDOWN, default 2500000, meaning the clock cycles during which input is ignored after a move.
REQ-006 SHALL have parameter RESPAWN_CYCLES, default 25000000, meaning the duration of the death pause in cycles.
REQ-007 SHALL provide ports: i_Clk input 1 system clock; i_Rst_L input 1 reset; i_Up, i_Down, i_Left, i_Right input 1 each, debounced button levels; i_Has_Collided input 1 collision flag from the collision checker.
REQ-008 SHALL provide outputs: o_Frog_X output 10 frog top-left X; o_Frog_Y output 9 frog top-left Y; o_Lives output 2 remaining lives; o_Level output 4 levels completed; o_Dying output 1 high during the death pause; o_Game_Over output 1 high when lives are exhausted.
REQ-009 SHALL use one clock, i_Clk; reset i_Rst_L is synchronous and active-low.

Function
REQ-010 SHALL implement states PLAY, COOLDOWN, DYING, GAME_OVER.
REQ-011 SHALL detect a press as a button sampled high in cycle n and low in cycle n-1; buttons not newly pressed are ignored.
REQ-012 SHALL, in PLAY on a press, move the frog one TILE_SIZE in that direction, with the new position on outputs at edge n+1, then enter COOLDOWN.
REQ-013 SHALL use priority Up > Down > Left > Right when several buttons are pressed in the same cycle; exactly one move occurs.
REQ-014 SHALL clamp moves: X stays within 0..640-TILE_SIZE, Y stays at or below START_Y; a clamped press still enters COOLDOWN.
REQ-015 SHALL stay in COOLDOWN for exactly MOVE_COOLDOWN cycles, ignoring presses, then return to PLAY.
REQ-016 SHALL, when a move lands at Y==0, on the next edge return the frog to START_X/START_Y, increment o_Level (saturating at 15), and leave o_Lives unchanged.
REQ-017 SHALL sample i_Has_Collided in PLAY and COOLDOWN; a collision takes priority over a press in the same cycle.
REQ-018 SHALL, on collision with o_Lives>1, decrement o_Lives, assert o_Dying, freeze the position, and enter DYING.
REQ-019 SHALL, on collision with o_Lives==1, set o_Lives=0, assert o_Game_Over, and enter GAME_OVER.
REQ-020 SHALL, after RESPAWN_CYCLES in DYING, reposition the frog to start, deassert o_Dying, and enter PLAY; i_Has_Collided is ignored during DYING.
REQ-021 SHALL, in GAME_OVER, hold all outputs until any press, then restart with o_Lives=LIVES, o_Level=0, frog at start, and state PLAY.
REQ-022 SHALL size the cooldown/respawn counter by $clog2 of the larger of the two durations; it must not wrap.

Reset
REQ-023 SHALL, while i_Rst_L==0 at an edge, set o_Frog_X=START_X, o_Frog_Y=START_Y, o_Lives=LIVES, o_Level=0, o_Dying=0, o_Game_Over=0, state PLAY, counters=0, and previous button samples=0.
REQ-024 SHALL let reset mid-COOLDOWN or mid-DYING abort immediately, with no residual count.

Configuration
REQ-025 SHALL, with FROG_WRAP_EN defined, wrap horizontal moves: Left at X=0 goes to 640-TILE_SIZE, and Right at 640-TILE_SIZE goes to 0.
REQ-026 SHALL, without FROG_WRAP_EN, clamp horizontal moves per REQ-014; vertical moves are clamped in both builds.

Structure
REQ-027 SHALL place TILE_SIZE, screen width 640 and height 480, spawn coordinates, and the state encoding in the shared package frog_pkg.
REQ-028 SHALL instantiate sub-module button_edge_detect four times, once per button, to produce single-cycle press pulses.

Verification (MOVE_COOLDOWN=4, RESPAWN_CYCLES=8, LIVES=3)
REQ-029 SHALL cover: Up press at (320,448) -> (320,416) one edge later; a second Up within 4 cycles -> no move; Up after cooldown -> (320,384).
REQ-030 SHALL cover: Left pressed 11 times spaced past cooldown from X=320 -> X reaches 0, then 0 without FROG_WRAP_EN and 608 with it.
REQ-031 SHALL cover: 14 spaced Up presses -> Y=0 reached, next edge frog at (320,448), o_Level=1, o_Lives=3.
REQ-032 SHALL cover: i_Has_Collided pulse together with a Right press -> no move, o_Lives=2, o_Dying=1 for 8 cycles, then frog at start.
REQ-033 SHALL cover: three collisions -> o_Lives=0 and o_Game_Over=1; a Down press -> o_Lives=3, o_Level=0, o_Game_Over=0.
REQ-034 SHALL cover: i_Rst_L low for one edge during DYING -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/frog_pkg.sv
`default_nettype none
// ============================================================================
// Module : frog_pkg -- shared geometry, spawn point and FSM encoding
// Rev    : 1.0
// ============================================================================
package frog_pkg;

    localparam int FROG_TILE_SIZE = 32;
    localparam int SCREEN_W       = 640;
    localparam int SCREEN_H       = 480;
    localparam int FROG_START_X   = 320;
    localparam int FROG_START_Y   = 448;

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        COOLDOWN  = 2'd1,
        DYING     = 2'd2,
        GAME_OVER = 2'd3
    } frog_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_edge_detect.sv
`default_nettype none
// ============================================================================
// Module : button_edge_detect -- one-cycle pulse on a low-to-high button edge
// Rev    : 1.0
// ============================================================================
module button_edge_detect (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Button,
    output logic o_Press
);

    logic r_prev;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_Button;
        end
    end

    assign o_Press = i_Button & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/frog_controller.sv
`default_nettype none
// ============================================================================
// Module : frog_controller -- frog movement, lives, levels and death/respawn
//          Define FROG_WRAP_EN to wrap horizontal moves instead of clamping.
// Rev    : 1.0
// ============================================================================
module frog_controller
    import frog_pkg::*;
#(
    parameter int TILE_SIZE      = FROG_TILE_SIZE,
    parameter int START_X        = FROG_START_X,
    parameter int START_Y        = FROG_START_Y,
    parameter int LIVES          = 3,
    parameter int MOVE_COOLDOWN  = 2500000,
    parameter int RESPAWN_CYCLES = 25000000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Up,
    input  logic       i_Down,
    input  logic       i_Left,
    input  logic       i_Right,
    input  logic       i_Has_Collided,
    output logic [9:0] o_Frog_X,
    output logic [8:0] o_Frog_Y,
    output logic [1:0] o_Lives,
    output logic [3:0] o_Level,
    output logic       o_Dying,
    output logic       o_Game_Over
);

    localparam int c_CNT_MAX = max_int(MOVE_COOLDOWN, RESPAWN_CYCLES);
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_MOVE_LAST = c_CNT_W'(MOVE_COOLDOWN - 1);
    localparam logic [c_CNT_W-1:0] c_RESP_LAST = c_CNT_W'(RESPAWN_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [9:0]         c_X_MAX     = 10'(SCREEN_W - TILE_SIZE);
    localparam logic [9:0]         c_TILE_X    = 10'(TILE_SIZE);
    localparam logic [8:0]         c_TILE_Y    = 9'(TILE_SIZE);
    localparam logic [9:0]         c_START_X   = 10'(START_X);
    localparam logic [8:0]         c_START_Y   = 9'(START_Y);
    localparam logic [1:0]         c_LIVES     = 2'(LIVES);

    // Bit order: [3]=Up, [2]=Down, [1]=Left, [0]=Right (priority high to low)
    logic [3:0] w_buttons;
    logic [3:0] w_press;
    logic       w_any_press;

    assign w_buttons   = {i_Up, i_Down, i_Left, i_Right};
    assign w_any_press = |w_press;

    for (genvar g = 0; g < 4; g++) begin : g_btn
        button_edge_detect u_edge (
            .i_Clk    (i_Clk),
            .i_Rst_L  (i_Rst_L),
            .i_Button (w_buttons[g]),
            .o_Press  (w_press[g])
        );
    end

    frog_state_t          r_state, w_next_state;
    logic [9:0]           r_x, w_next_x;
    logic [8:0]           r_y, w_next_y;
    logic [1:0]           r_lives, w_next_lives;
    logic [3:0]           r_level, w_next_level;
    logic                 r_dying, w_next_dying;
    logic                 r_game_over, w_next_game_over;
    logic [c_CNT_W-1:0]   r_cnt, w_next_cnt;

    // Candidate positions for each direction, already clamped or wrapped
    logic [8:0]  w_up_y;
    logic [9:0]  w_down_sum;
    logic [8:0]  w_down_y;
    logic [9:0]  w_left_x;
    logic [10:0] w_right_sum;
    logic [9:0]  w_right_x;

    assign w_up_y      = (r_y < c_TILE_Y) ? 9'd0 : (r_y - c_TILE_Y);
    assign w_down_sum  = {1'b0, r_y} + 10'(TILE_SIZE);
    assign w_down_y    = (w_down_sum > 10'(START_Y)) ? c_START_Y : w_down_sum[8:0];
    assign w_right_sum = {1'b0, r_x} + 11'(TILE_SIZE);

`ifdef FROG_WRAP_EN
    assign w_left_x  = (r_x < c_TILE_X) ? c_X_MAX : (r_x - c_TILE_X);
    assign w_right_x = (w_right_sum > {1'b0, c_X_MAX}) ? 10'd0 : w_right_sum[9:0];
`else
    assign w_left_x  = (r_x < c_TILE_X) ? 10'd0 : (r_x - c_TILE_X);
    assign w_right_x = (w_right_sum > {1'b0, c_X_MAX}) ? c_X_MAX : w_right_sum[9:0];
`endif

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_state     <= PLAY;
            r_x         <= c_START_X;
            r_y         <= c_START_Y;
            r_lives     <= c_LIVES;
            r_level     <= 4'd0;
            r_dying     <= 1'b0;
            r_game_over <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_next_state;
            r_x         <= w_next_x;
            r_y         <= w_next_y;
            r_lives     <= w_next_lives;
            r_level     <= w_next_level;
            r_dying     <= w_next_dying;
            r_game_over <= w_next_game_over;
            r_cnt       <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_x         = r_x;
        w_next_y         = r_y;
        w_next_lives     = r_lives;
        w_next_level     = r_level;
        w_next_dying     = r_dying;
        w_next_game_over = r_game_over;
        w_next_cnt       = r_cnt;

        // Collision outranks any press; the position stays frozen where it hit
        if ((r_state == PLAY || r_state == COOLDOWN) && i_Has_Collided) begin
            w_next_cnt = '0;
            if (r_lives > 2'd1) begin
                w_next_lives = r_lives - 2'd1;
                w_next_dying = 1'b1;
                w_next_state = DYING;
            end else begin
                w_next_lives     = 2'd0;
                w_next_game_over = 1'b1;
                w_next_state     = GAME_OVER;
            end
        end else begin
            unique case (r_state)
                PLAY: begin
                    if (w_any_press) begin
                        if (w_press[3])      w_next_y = w_up_y;
                        else if (w_press[2]) w_next_y = w_down_y;
                        else if (w_press[1]) w_next_x = w_left_x;
                        else                 w_next_x = w_right_x;
                        w_next_cnt   = '0;
                        w_next_state = COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    // Reaching the top row scores a level one edge after the move
                    if (r_y == 9'd0) begin
                        w_next_x     = c_START_X;
                        w_next_y     = c_START_Y;
                        w_next_level = (r_level == 4'hF) ? r_level : (r_level + 4'd1);
                    end
                    if (r_cnt == c_MOVE_LAST) begin
                        w_next_cnt   = '0;
                        w_next_state = PLAY;
                    end else begin
                        w_next_cnt = r_cnt + c_CNT_ONE;
                    end
                end
                DYING: begin
                    if (r_cnt == c_RESP_LAST) begin
                        w_next_cnt   = '0;
                        w_next_x     = c_START_X;
                        w_next_y     = c_START_Y;
                        w_next_dying = 1'b0;
                        w_next_state = PLAY;
                    end else begin
                        w_next_cnt = r_cnt + c_CNT_ONE;
                    end
                end
                GAME_OVER: begin
                    if (w_any_press) begin
                        w_next_lives     = c_LIVES;
                        w_next_level     = 4'd0;
                        w_next_x         = c_START_X;
                        w_next_y         = c_START_Y;
                        w_next_game_over = 1'b0;
                        w_next_cnt       = '0;
                        w_next_state     = PLAY;
                    end
                end
            endcase
        end
    end

    assign o_Frog_X    = r_x;
    assign o_Frog_Y    = r_y;
    assign o_Lives     = r_lives;
    assign o_Level     = r_level;
    assign o_Dying     = r_dying;
    assign o_Game_Over = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_frog_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_frog_controller -- directed self-checking bench for frog_controller
// Rev    : 1.0
// ============================================================================
module tb_frog_controller;

    localparam int c_MC  = 4;
    localparam int c_RC  = 8;
    localparam int c_UP  = 0;
    localparam int c_DN  = 1;
    localparam int c_LF  = 2;
    localparam int c_RT  = 3;
`ifdef FROG_WRAP_EN
    localparam int c_LEFT_EDGE = 608;
`else
    localparam int c_LEFT_EDGE = 0;
`endif

    logic       r_clk = 1'b0;
    logic       r_rst_l = 1'b0;
    logic       r_up = 1'b0, r_down = 1'b0, r_left = 1'b0, r_right = 1'b0;
    logic       r_coll = 1'b0;
    logic [9:0] w_x;
    logic [8:0] w_y;
    logic [1:0] w_lives;
    logic [3:0] w_level;
    logic       w_dying;
    logic       w_go;

    int checks   = 0;
    int failures = 0;
    int n_dying;

    always #5 r_clk = ~r_clk;

    frog_controller #(
        .TILE_SIZE      (32),
        .START_X        (320),
        .START_Y        (448),
        .LIVES          (3),
        .MOVE_COOLDOWN  (c_MC),
        .RESPAWN_CYCLES (c_RC)
    ) u_dut (
        .i_Clk          (r_clk),
        .i_Rst_L        (r_rst_l),
        .i_Up           (r_up),
        .i_Down         (r_down),
        .i_Left         (r_left),
        .i_Right        (r_right),
        .i_Has_Collided (r_coll),
        .o_Frog_X       (w_x),
        .o_Frog_Y       (w_y),
        .o_Lives        (w_lives),
        .o_Level        (w_level),
        .o_Dying        (w_dying),
        .o_Game_Over    (w_go)
    );

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic press(input int btn);
        case (btn)
            c_UP:    r_up    = 1'b1;
            c_DN:    r_down  = 1'b1;
            c_LF:    r_left  = 1'b1;
            default: r_right = 1'b1;
        endcase
        tick();
        r_up = 1'b0; r_down = 1'b0; r_left = 1'b0; r_right = 1'b0;
    endtask

    task automatic move(input int btn);
        press(btn);
        idle(c_MC + 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_x"},     32'(w_x),     320);
        check({tag, "_y"},     32'(w_y),     448);
        check({tag, "_lives"}, 32'(w_lives), 3);
        check({tag, "_level"}, 32'(w_level), 0);
        check({tag, "_dying"}, 32'(w_dying), 0);
        check({tag, "_go"},    32'(w_go),    0);
    endtask

    task automatic wait_dying_end();
        for (int i = 0; i < 20 && w_dying; i++) tick();
        check("dying_ends", 32'(w_dying), 0);
    endtask

    initial begin
        idle(2);
        r_rst_l = 1'b1;
        check_reset_state("reset");

        // Up, blocked Up during cooldown, Up after cooldown
        press(c_UP);
        check("up1_y", 32'(w_y), 416);
        tick();
        press(c_UP);
        check("up_in_cooldown_y", 32'(w_y), 416);
        idle(3);
        press(c_UP);
        check("up2_y", 32'(w_y), 384);
        idle(c_MC + 1);

        // Walk left to the edge, then one more
        for (int i = 0; i < 10; i++) move(c_LF);
        check("left10_x", 32'(w_x), 0);
        press(c_LF);
        check("left11_x", 32'(w_x), c_LEFT_EDGE);
        idle(c_MC + 1);

        // Down to spawn row, then clamped Down
        move(c_DN);
        move(c_DN);
        check("down_to_start_y", 32'(w_y), 448);
        press(c_DN);
        check("down_clamp_y", 32'(w_y), 448);
        idle(c_MC + 1);

        // Up and Down together: Up wins
        r_up = 1'b1; r_down = 1'b1;
        tick();
        r_up = 1'b0; r_down = 1'b0;
        check("priority_y", 32'(w_y), 416);
        idle(c_MC + 1);

        r_rst_l = 1'b0;
        tick();
        r_rst_l = 1'b1;
        check_reset_state("reset2");

        // Climb to the top row
        for (int i = 0; i < 13; i++) move(c_UP);
        check("up13_y", 32'(w_y), 32);
        press(c_UP);
        check("top_y", 32'(w_y), 0);
        tick();
        check("level_x", 32'(w_x), 320);
        check("level_y", 32'(w_y), 448);
        check("level_lvl", 32'(w_level), 1);
        check("level_lives", 32'(w_lives), 3);
        idle(c_MC + 1);

        // Collision with a simultaneous Right press
        move(c_UP);
        r_right = 1'b1; r_coll = 1'b1;
        tick();
        r_right = 1'b0; r_coll = 1'b0;
        check("hit_x", 32'(w_x), 320);
        check("hit_y", 32'(w_y), 416);
        check("hit_lives", 32'(w_lives), 2);
        check("hit_dying", 32'(w_dying), 1);
        n_dying = 1;
        r_coll = 1'b1;
        tick();
        r_coll = 1'b0;
        if (w_dying) n_dying++;
        check("hit_ignored_lives", 32'(w_lives), 2);
        for (int i = 0; i < 20 && w_dying; i++) begin
            tick();
            if (w_dying) n_dying++;
        end
        check("dying_cycles", 32'(n_dying), 8);
        check("respawn_dying", 32'(w_dying), 0);
        check("respawn_x", 32'(w_x), 320);
        check("respawn_y", 32'(w_y), 448);
        check("respawn_level", 32'(w_level), 1);

        // Two more collisions exhaust lives
        r_coll = 1'b1;
        tick();
        r_coll = 1'b0;
        check("hit2_lives", 32'(w_lives), 1);
        wait_dying_end();
        r_coll = 1'b1;
        tick();
        r_coll = 1'b0;
        check("hit3_lives", 32'(w_lives), 0);
        check("hit3_go", 32'(w_go), 1);
        check("hit3_dying", 32'(w_dying), 0);
        idle(3);
        check("go_hold", 32'(w_go), 1);
        press(c_DN);
        check("restart_lives", 32'(w_lives), 3);
        check("restart_level", 32'(w_level), 0);
        check("restart_go", 32'(w_go), 0);
        check("restart_x", 32'(w_x), 320);
        check("restart_y", 32'(w_y), 448);
        idle(2);

        // Reset in the middle of the death pause
        move(c_UP);
        r_coll = 1'b1;
        tick();
        r_coll = 1'b0;
        check("hit4_dying", 32'(w_dying), 1);
        idle(3);
        r_rst_l = 1'b0;
        tick();
        r_rst_l = 1'b1;
        check_reset_state("reset_dying");
        idle(10);
        check("post_reset_dying", 32'(w_dying), 0);
        press(c_UP);
        check("post_reset_up_y", 32'(w_y), 416);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
